// File: rtl/ram_port_arbiter.sv
// Two-master (A: fetch, read-only; B: data, read/write) sequencer in front of a
// single-port registered-read RAM. Define RAM_ARB_RR_EN for round-robin arbitration.
module ram_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_req_i,
  input  logic [ADDR_W-1:0]     a_adr_i,
  output logic                  a_ack_o,
  output logic [DATA_W-1:0]     a_dat_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [DATA_W/8-1:0]   b_be_i,
  input  logic [ADDR_W-1:0]     b_adr_i,
  input  logic [DATA_W-1:0]     b_dat_i,
  output logic                  b_ack_o,
  output logic [DATA_W-1:0]     b_dat_o,
  output logic                  ram_we_o,
  output logic [DATA_W/8-1:0]   ram_be_o,
  output logic [ADDR_W-1:0]     ram_adr_o,
  output logic [DATA_W-1:0]     ram_dat_o,
  input  logic [DATA_W-1:0]     ram_dat_i
);
  localparam int BE_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  typedef struct packed {
    logic              port_b;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } ram_req_t;

  state_t   state_q, state_d;
  logic     take, fire;
  logic     pick_b;
  ram_req_t win;
  logic     gnt_b_q;
  logic     rd_q;

`ifdef RAM_ARB_RR_EN
  // Pointer holds the last granted port; on a conflict the other port wins.
  logic last_b_q;
  always_comb pick_b = b_req_i && (!a_req_i || !last_b_q);

  always_ff @(posedge clk_i) begin
    if (rst_i)     last_b_q <= 1'b0;
    else if (take) last_b_q <= pick_b;
  end
`else
  always_comb pick_b = b_req_i;
`endif

  always_comb begin
    win = '0;
    if (pick_b) begin
      win.port_b = 1'b1;
      win.we     = b_we_i;
      win.be     = b_be_i;
      win.adr    = b_adr_i;
      win.dat    = b_dat_i;
    end else begin
      win.adr    = a_adr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE:    if (a_req_i || b_req_i) begin
                 take    = 1'b1;
                 state_d = ISSUE;
               end
      ISSUE:   state_d = WAIT;
      WAIT:    begin
                 fire    = 1'b1;
                 state_d = ACK;
               end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe/enables live for the ISSUE cycle only: loaded on grant, cleared on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_ack_o   <= 1'b0;
      b_ack_o   <= 1'b0;
      a_dat_o   <= '0;
      b_dat_o   <= '0;
      ram_we_o  <= 1'b0;
      ram_be_o  <= '0;
      ram_adr_o <= '0;
      ram_dat_o <= '0;
      gnt_b_q   <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      a_ack_o <= fire && !gnt_b_q;
      b_ack_o <= fire &&  gnt_b_q;
      if (take) begin
        gnt_b_q   <= win.port_b;
        rd_q      <= !win.we;
        ram_we_o  <= win.we;
        ram_be_o  <= win.be;
        ram_adr_o <= win.adr;
        ram_dat_o <= win.dat;
      end else begin
        ram_we_o  <= 1'b0;
        ram_be_o  <= '0;
      end
      if (fire && rd_q) begin
        if (gnt_b_q) b_dat_o <= ram_dat_i;
        else         a_dat_o <= ram_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          a_req_i, b_req_i, b_we_i;
  logic [AW-1:0] a_adr_i, b_adr_i;
  logic [3:0]    b_be_i;
  logic [DW-1:0] b_dat_i;
  logic          a_ack_o, b_ack_o, ram_we_o;
  logic [DW-1:0] a_dat_o, b_dat_o, ram_dat_o, ram_dat_i;
  logic [3:0]    ram_be_o;
  logic [AW-1:0] ram_adr_o;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_req_i(a_req_i), .a_adr_i(a_adr_i), .a_ack_o(a_ack_o), .a_dat_o(a_dat_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_adr_i(b_adr_i),
    .b_dat_i(b_dat_i), .b_ack_o(b_ack_o), .b_dat_o(b_dat_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
  );

  // RAM model: word i starts as 32'hC0DE0000 | i, no reset afterwards.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] wword;
  logic          tb_init;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'hC0DE0000 | i;
    end else if (ram_we_o) begin
      wword = mem[ram_adr_o];
      for (int i = 0; i < 4; i++)
        if (ram_be_o[i]) wword[8*i +: 8] = ram_dat_o[8*i +: 8];
      mem[ram_adr_o] <= wword;
    end
    ram_dat_i <= mem[ram_adr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  typedef struct {
    bit          port_b;
    bit          rd;
    logic [31:0] dat;
  } exp_t;
  exp_t sbq[$];

  function automatic exp_t mk(input bit port_b, input bit rd, input logic [31:0] dat);
    exp_t e;
    e.port_b = port_b; e.rd = rd; e.dat = dat;
    return e;
  endfunction

  // Monitor: pops one expectation per ack, checks one-hot acks and strobe width.
  logic [31:0] hold_b = '0;
  bit          prev_ack = 1'b0;
  int          we_run = 0;
  int          we_cycles = 0;
  always @(negedge clk) begin
    if (rst_i) begin
      hold_b   = '0;
      prev_ack = 1'b0;
      we_run   = 0;
    end else begin
      if (a_ack_o && b_ack_o) chk("both_acks", 32'd1, 32'd0);
      if (a_ack_o || b_ack_o) begin
        chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {31'd0, b_ack_o}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_port_b", {31'd0, b_ack_o}, {31'd0, e.port_b});
          if (e.rd) begin
            if (e.port_b) begin
              chk("b_rd_dat", b_dat_o, e.dat);
              hold_b = e.dat;
            end else begin
              chk("a_rd_dat", a_dat_o, e.dat);
            end
          end else begin
            chk("b_dat_held_on_write", b_dat_o, hold_b);
          end
        end
      end
      prev_ack = a_ack_o || b_ack_o;
      if (ram_we_o) begin
        we_run++;
        we_cycles++;
        if (we_run > 1) chk("we_width", we_run, 32'd1);
      end else begin
        we_run = 0;
      end
    end
  end

  task automatic b_op(input bit we, input logic [3:0] be, input logic [AW-1:0] adr,
                      input logic [31:0] dat, input bit keep,
                      output int ack_cyc, output logic [AW-1:0] adr_seen);
    int n;
    n = 0;
    b_req_i = 1'b1; b_we_i = we; b_be_i = be; b_adr_i = adr; b_dat_i = dat;
    @(negedge clk);
    while (!b_ack_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("b_ack_timeout", {31'd0, b_ack_o}, 32'd1);
    ack_cyc  = cyc;
    adr_seen = ram_adr_o;
    if (!keep) b_req_i = 1'b0;
  endtask

  task automatic a_op(input logic [AW-1:0] adr, input bit keep,
                      output int ack_cyc, output logic [AW-1:0] adr_seen);
    int n;
    n = 0;
    a_req_i = 1'b1; a_adr_i = adr;
    @(negedge clk);
    while (!a_ack_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("a_ack_timeout", {31'd0, a_ack_o}, 32'd1);
    ack_cyc  = cyc;
    adr_seen = ram_adr_o;
    if (!keep) a_req_i = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_a_ack", {31'd0, a_ack_o}, 32'd0);
    chk("rst_b_ack", {31'd0, b_ack_o}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
    chk("rst_ram_be", {28'd0, ram_be_o}, 32'd0);
    chk("rst_ram_adr", {20'd0, ram_adr_o}, 32'd0);
    chk("rst_ram_dat", ram_dat_o, 32'd0);
    chk("rst_a_dat", a_dat_o, 32'd0);
    chk("rst_b_dat", b_dat_o, 32'd0);
  endtask

  int            t0, c0, c1, ca, cb, w0;
  int            acyc [4];
  logic [AW-1:0] xs, xa, xb;

  initial begin
    rst_i = 1'b1; tb_init = 1'b1;
    a_req_i = 1'b0; a_adr_i = '0;
    b_req_i = 1'b0; b_we_i = 1'b0; b_be_i = '0; b_adr_i = '0; b_dat_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0; tb_init = 1'b0;
    chk_reset();
    @(negedge clk);

    // 1: full-word write then read-back; write latency and strobe width
    w0 = we_cycles;
    sbq.push_back(mk(1'b1, 1'b0, '0));
    t0 = cyc;
    b_op(1'b1, 4'b1111, 12'h005, 32'hDEADBEEF, 1'b0, c0, xs);
    chk("t1_latency", c0 - t0, 32'd3);
    chk("t1_we_cycles", we_cycles - w0, 32'd1);
    sbq.push_back(mk(1'b1, 1'b1, 32'hDEADBEEF));
    b_op(1'b0, 4'b0000, 12'h005, '0, 1'b0, c0, xs);

    // 2: byte-lane merge, then fetch port sees it
    w0 = we_cycles;
    sbq.push_back(mk(1'b1, 1'b0, '0));
    b_op(1'b1, 4'b0010, 12'h005, 32'h0000AA00, 1'b0, c0, xs);
    chk("t2_we_cycles", we_cycles - w0, 32'd1);
    sbq.push_back(mk(1'b0, 1'b1, 32'hDEADAAEF));
    a_op(12'h005, 1'b0, c0, xs);
    repeat (2) @(negedge clk);

    // 3: both ports request together, three transactions each
`ifdef RAM_ARB_RR_EN
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0010));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0001));
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0011));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0002));
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0012));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0003));
`else
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0010));
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0011));
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0012));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0001));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0002));
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0003));
`endif
    fork
      begin
        a_op(12'h001, 1'b1, ca, xa);
        a_op(12'h002, 1'b1, ca, xa);
        a_op(12'h003, 1'b0, ca, xa);
      end
      begin
        b_op(1'b0, 4'b0000, 12'h010, '0, 1'b1, cb, xb);
        b_op(1'b0, 4'b0000, 12'h011, '0, 1'b1, cb, xb);
        b_op(1'b0, 4'b0000, 12'h012, '0, 1'b0, cb, xb);
      end
    join
    repeat (2) @(negedge clk);

    // 4: A holds req across four reads; acks exactly four cycles apart
    for (int i = 0; i < 4; i++) sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0000 | i));
    for (int i = 0; i < 4; i++) a_op(i[AW-1:0], (i != 3), acyc[i], xs);
    for (int i = 1; i < 4; i++) chk("t4_ack_spacing", acyc[i] - acyc[i-1], 32'd4);
    repeat (2) @(negedge clk);

    // 5: reset lands while a B read is in WAIT
    b_req_i = 1'b1; b_we_i = 1'b0; b_be_i = '0; b_adr_i = 12'h007;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1; b_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    chk_reset();
    repeat (4) @(negedge clk);
    chk("t5_no_stray_ack", {30'd0, a_ack_o, b_ack_o}, 32'd0);
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0007));
    a_op(12'h007, 1'b0, c1, xs);
    repeat (2) @(negedge clk);

    // 6: top and bottom of the address space
    sbq.push_back(mk(1'b1, 1'b1, 32'hC0DE0FFF));
    b_op(1'b0, 4'b0000, 12'hFFF, '0, 1'b0, c0, xs);
    chk("t6_adr_fff", {20'd0, xs}, 32'h0000_0FFF);
    sbq.push_back(mk(1'b0, 1'b1, 32'hC0DE0000));
    a_op(12'h000, 1'b0, c0, xs);
    chk("t6_adr_000", {20'd0, xs}, 32'h0000_0000);

    repeat (6) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
